vid_crop: RTL and testbench
===========================

// Module: vid_crop
// PURPOSE
//  Window crop on a de/hs/vs pixel stream; sits directly downstream of scaler_v (before monitor/output).
//  Passes only pixels inside [x_start, x_start+x_size) x [y_start, y_start+y_size); hs/vs pass through.
//  Reports cropped line length on pix_count_o, same meaning as scaler_h pix_count_o for the next stage.
// PARAMETERS
//  DATA_WIDTH   8   pixel width, bits
//  CNT_WIDTH    16  width of pixel/line counters and window inputs
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous reset, active high
//  x_start_i    in   CNT_WIDTH   first kept pixel in a line (0-based)
//  x_size_i     in   CNT_WIDTH   kept pixels per line; 0 = none
//  y_start_i    in   CNT_WIDTH   first kept line in a frame (0-based)
//  y_size_i     in   CNT_WIDTH   kept lines per frame; 0 = none
//  di_i         in   DATA_WIDTH  pixel data, valid when de_i=1
//  de_i         in   1           pixel valid; any duty cycle (sparse or dense)
//  hs_i         in   1           1 = horizontal blank, 0 = inside line
//  vs_i         in   1           1 = vertical blank, 0 = inside frame
//  do_o         out  DATA_WIDTH  cropped pixel
//  de_o         out  1           cropped pixel valid
//  hs_o/vs_o    out  1           hs_i/vs_i delayed 1 clk
//  pix_count_o  out  CNT_WIDTH   de_o count of last completed line
// BEHAVIOUR
//  - Reset: do_o=0, de_o=0, hs_o=1, vs_o=1, pix_count_o=0, counters=0, FSM=S_SYNC.
//  - Latency: 1 clk on all outputs; every output is registered.
//  - FSM: S_SYNC --vs_i=1--> S_VBLANK --vs_i=0--> S_ACTIVE --vs_i=1--> S_VBLANK.
//    de_o held 0 in S_SYNC and S_VBLANK; hs_o/vs_o still follow inputs in every state.
//    Reset mid-frame: output is suppressed until the next full vs_i 1->0 cycle.
//  - Window regs: x_start/x_size/y_start/y_size are sampled on S_VBLANK->S_ACTIVE only.
//    Mid-frame changes on the inputs take effect at the next frame.
//  - xcnt: cleared while hs_i=1; +1 per de_i=1 clk. Saturates at all-ones.
//  - ycnt: cleared while vs_i=1; +1 on hs_i rising edge (end of line). Saturates.
//    hs_i and vs_i rising together (last line): that line is counted and ycnt is then cleared.
//  - Keep pixel when de_i & S_ACTIVE & xcnt>=xs & (xcnt-xs)<xsz & ycnt>=ys & (ycnt-ys)<ysz.
//    Compare at CNT_WIDTH+1 bits so start+size never wraps.
//  - Window larger than image: only the overlap is output. Window fully outside: no de_o.
//  - do_o holds its last value when de_o=0.
//  - pix_count_o: line de_o counter is loaded into pix_count_o on hs_o rising edge, then cleared.
//    Lines outside the y window load 0.
// CONFIGURATION
//  VID_CROP_STAT_EN defined:
//    adds ports frame_w_o, frame_h_o (out, CNT_WIDTH), both reset to 0.
//    frame_w_o = de_i count of the last input line; frame_h_o = line count of the last input frame.
//    Both latch on the vs_i rising edge; frames seen in S_SYNC are not reported.
//  VID_CROP_STAT_EN undefined: those ports and their logic are absent; all other behaviour identical.
// TESTING
//  1 600x600 dense, window 0/600/0/600 -> output identical to input delayed 1 clk; pix_count_o=600.
//  2 600x600, DE period 4, window x100/200, y50/300 -> 300 lines x 200 px.
//    First kept pixel = input (100,50); pix_count_o=200.
//  3 Window x550/100, y590/20 -> 50 px x 10 lines; pix_count_o=50 on kept lines, 0 elsewhere.
//  4 x_size=0 or x_start=700 -> de_o never 1; hs_o/vs_o still toggle 1 clk after inputs.
//  5 rst at line 300, frame 0 -> de_o=0 for rest of frame 0.
//    Frame 1 cropped correctly; window change mid-frame 1 -> applied at frame 2.
//  6 VID_CROP_STAT_EN, 600x600 input, 2 frames -> frame_w_o=600, frame_h_o=600 after frame 0 vs_i rise.

Source files
------------

// File: rtl/vid_crop.sv
// -----------------------------------------------------------------------------
// vid_crop
//   Rectangular window crop on a de/hs/vs pixel stream. Only pixels inside
//   [x_start, x_start+x_size) x [y_start, y_start+y_size) are forwarded on
//   de_o/do_o. hs/vs are passed through with one clock of delay. pix_count_o
//   reports how many pixels the last completed output line carried.
//
//   Optional feature macro: VID_CROP_STAT_EN
//     When defined, frame_w_o / frame_h_o report the input line length and
//     input frame height of the last completed frame.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   x_start_i       first kept pixel in a line (0-based)
//   x_size_i        kept pixels per line (0 = none)
//   y_start_i       first kept line in a frame (0-based)
//   y_size_i        kept lines per frame (0 = none)
//   di_i, de_i      input pixel data and valid
//   hs_i, vs_i      1 = horizontal / vertical blank
//   do_o, de_o      cropped pixel data and valid (do_o holds when de_o=0)
//   hs_o, vs_o      hs_i / vs_i delayed by one clock
//   pix_count_o     de_o count of the last completed line
//   frame_w_o       (VID_CROP_STAT_EN) de_i count of the last input line
//   frame_h_o       (VID_CROP_STAT_EN) line count of the last input frame
// -----------------------------------------------------------------------------
module vid_crop #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_WIDTH-1:0]  x_start_i,
  input  logic [CNT_WIDTH-1:0]  x_size_i,
  input  logic [CNT_WIDTH-1:0]  y_start_i,
  input  logic [CNT_WIDTH-1:0]  y_size_i,
  input  logic [DATA_WIDTH-1:0] di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic [CNT_WIDTH-1:0]  pix_count_o
`ifdef VID_CROP_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0]  frame_w_o,
  output logic [CNT_WIDTH-1:0]  frame_h_o
`endif
);

  typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_ACTIVE} state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_xcnt;
  logic [CNT_WIDTH-1:0]  r_ycnt;
  logic [CNT_WIDTH-1:0]  r_xs;
  logic [CNT_WIDTH-1:0]  r_xsz;
  logic [CNT_WIDTH-1:0]  r_ys;
  logic [CNT_WIDTH-1:0]  r_ysz;
  logic [CNT_WIDTH-1:0]  r_line_cnt;
  logic [CNT_WIDTH-1:0]  r_pix_count_p1;
  logic [DATA_WIDTH-1:0] r_do_p1;
  logic                  r_de_p1;
  logic                  r_hs_p1;
  logic                  r_vs_p1;

  logic                  w_hs_rise;
  logic                  w_vs_rise;
  logic [CNT_WIDTH:0]    w_x_end;
  logic [CNT_WIDTH:0]    w_y_end;
  logic                  w_x_in;
  logic                  w_y_in;
  logic                  w_keep;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // The registered hs/vs outputs double as the previous-cycle samples.
  assign w_hs_rise = hs_i & ~r_hs_p1;
  assign w_vs_rise = vs_i & ~r_vs_p1;

  // Window end computed one bit wider so start+size never wraps.
  assign w_x_end = {1'b0, r_xs} + {1'b0, r_xsz};
  assign w_y_end = {1'b0, r_ys} + {1'b0, r_ysz};
  assign w_x_in  = ({1'b0, r_xcnt} >= {1'b0, r_xs}) && ({1'b0, r_xcnt} < w_x_end);
  assign w_y_in  = ({1'b0, r_ycnt} >= {1'b0, r_ys}) && ({1'b0, r_ycnt} < w_y_end);
  assign w_keep  = de_i && (r_state == S_ACTIVE) && w_x_in && w_y_in;

  // ---- stage p0 -> p1: counters, window decision, registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_SYNC;
      r_xcnt         <= '0;
      r_ycnt         <= '0;
      r_xs           <= '0;
      r_xsz          <= '0;
      r_ys           <= '0;
      r_ysz          <= '0;
      r_line_cnt     <= '0;
      r_pix_count_p1 <= '0;
      r_do_p1        <= '0;
      r_de_p1        <= 1'b0;
      r_hs_p1        <= 1'b1;
      r_vs_p1        <= 1'b1;
    end else begin
      r_hs_p1 <= hs_i;
      r_vs_p1 <= vs_i;
      r_de_p1 <= w_keep;
      if (w_keep) begin
        r_do_p1 <= di_i;
      end

      if (hs_i) begin
        r_xcnt <= '0;
      end else if (de_i) begin
        r_xcnt <= sat_inc(r_xcnt);
      end

      // vs clear wins over the end-of-line increment on the last line.
      if (vs_i) begin
        r_ycnt <= '0;
      end else if (w_hs_rise) begin
        r_ycnt <= sat_inc(r_ycnt);
      end

      // Line output count is published on the same edge hs_o rises.
      if (w_hs_rise) begin
        r_pix_count_p1 <= r_line_cnt;
        r_line_cnt     <= w_keep ? CNT_WIDTH'(1) : '0;
      end else if (w_keep) begin
        r_line_cnt <= sat_inc(r_line_cnt);
      end

      case (r_state)
        S_SYNC: begin
          if (vs_i) r_state <= S_VBLANK;
        end
        S_VBLANK: begin
          if (!vs_i) begin
            r_state <= S_ACTIVE;
            r_xs    <= x_start_i;
            r_xsz   <= x_size_i;
            r_ys    <= y_start_i;
            r_ysz   <= y_size_i;
          end
        end
        S_ACTIVE: begin
          if (vs_i) r_state <= S_VBLANK;
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

  assign do_o        = r_do_p1;
  assign de_o        = r_de_p1;
  assign hs_o        = r_hs_p1;
  assign vs_o        = r_vs_p1;
  assign pix_count_o = r_pix_count_p1;

`ifdef VID_CROP_STAT_EN
  logic [CNT_WIDTH-1:0] r_line_w;
  logic [CNT_WIDTH-1:0] r_frame_w;
  logic [CNT_WIDTH-1:0] r_frame_h;

  // ---- stage p0 -> p1: input frame statistics ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_w  <= '0;
      r_frame_w <= '0;
      r_frame_h <= '0;
    end else begin
      if (w_hs_rise) begin
        r_line_w <= r_xcnt;
      end
      // Only frames that started after sync (state S_ACTIVE) are reported.
      // When hs and vs rise together the closing line is still in the counters.
      if (w_vs_rise && (r_state == S_ACTIVE)) begin
        r_frame_w <= w_hs_rise ? r_xcnt : r_line_w;
        r_frame_h <= w_hs_rise ? sat_inc(r_ycnt) : r_ycnt;
      end
    end
  end

  assign frame_w_o = r_frame_w;
  assign frame_h_o = r_frame_h;
`endif

endmodule

// File: tb/tb_vid_crop.sv
// -----------------------------------------------------------------------------
// tb_vid_crop
//   Randomized bench for vid_crop. A frame generator knows the (x, y) position
//   of every pixel it emits; the reference decides at frame level which pixels
//   fall into the window latched at frame start and what each output must be.
// -----------------------------------------------------------------------------
module tb_vid_crop;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int IMG_W = 40;
  localparam int IMG_H = 30;
  localparam int HB = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] x_start, x_size, y_start, y_size;
  logic [DW-1:0] di;
  logic          de, hs, vs;
  logic [DW-1:0] do_o;
  logic          de_o, hs_o, vs_o;
  logic [CW-1:0] pix_count_o;
`ifdef VID_CROP_STAT_EN
  logic [CW-1:0] frame_w_o, frame_h_o;
`endif

  vid_crop #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .x_start_i  (x_start),
    .x_size_i   (x_size),
    .y_start_i  (y_start),
    .y_size_i   (y_size),
    .di_i       (di),
    .de_i       (de),
    .hs_i       (hs),
    .vs_i       (vs),
    .do_o       (do_o),
    .de_o       (de_o),
    .hs_o       (hs_o),
    .vs_o       (vs_o),
    .pix_count_o(pix_count_o)
`ifdef VID_CROP_STAT_EN
    ,
    .frame_w_o  (frame_w_o),
    .frame_h_o  (frame_h_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state (frame-level view of the stream)
  int m_synced, m_fvalid, m_prev_hs, m_prev_vs, m_line_kept;
  int wxs, wxsz, wys, wysz;
  int e_de, e_do, e_hs, e_vs, e_pc, e_fw, e_fh;
  int g_w, g_h;
  int de_seen;
  int v_pc;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_win(input int a, input int b, input int c, input int d);
    x_start = CW'(a);
    x_size  = CW'(b);
    y_start = CW'(c);
    y_size  = CW'(d);
  endtask

  // One clock: drive inputs, predict outputs, then compare after the edge.
  task automatic step(input bit r, input bit v, input bit h, input bit d,
                      input int x, input int y);
    bit keep;
    rst = r;
    vs  = v;
    hs  = h;
    de  = d;
    di  = DW'($urandom);
    if (r) begin
      e_de = 0; e_do = 0; e_hs = 1; e_vs = 1; e_pc = 0; e_fw = 0; e_fh = 0;
      m_synced = 0; m_fvalid = 0; m_line_kept = 0; m_prev_hs = 1; m_prev_vs = 1;
    end else begin
      keep = d && (m_fvalid != 0) && (x >= wxs) && (x < wxs + wxsz) &&
             (y >= wys) && (y < wys + wysz);
      e_de = keep;
      if (keep) e_do = int'(di);
      if (h && !m_prev_hs) begin
        e_pc = m_line_kept;
        m_line_kept = keep;
      end else if (keep) begin
        m_line_kept++;
      end
      if (v && !m_prev_vs) begin
        if (m_fvalid != 0) begin
          e_fw = g_w;
          e_fh = g_h;
        end
        m_fvalid = 0;
      end
      if (!v && m_prev_vs && m_synced != 0) begin
        m_fvalid = 1;
        wxs = int'(x_start); wxsz = int'(x_size);
        wys = int'(y_start); wysz = int'(y_size);
      end
      if (v) m_synced = 1;
      e_hs = h;
      e_vs = v;
      m_prev_hs = h;
      m_prev_vs = v;
    end
    @(posedge clk);
    #1;
    check("de_o", de_o, e_de);
    check("hs_o", hs_o, e_hs);
    check("vs_o", vs_o, e_vs);
    check("do_o", do_o, e_do);
    check("pix_count_o", pix_count_o, e_pc);
`ifdef VID_CROP_STAT_EN
    check("frame_w_o", frame_w_o, e_fw);
    check("frame_h_o", frame_h_o, e_fh);
`endif
    if (de_o) de_seen++;
  endtask

  // Vertical blank: vs and hs rise together, blank lines, ends with hs=1.
  task automatic vblank();
    step(0, 1, 1, 0, -1, -1);
    v_pc = int'(pix_count_o);
    repeat (HB - 1) step(0, 1, 1, 0, -1, -1);
    repeat (2) begin
      repeat (8) step(0, 1, 0, 0, -1, -1);
      repeat (HB) step(0, 1, 1, 0, -1, -1);
    end
  endtask

  // Active frame. per>0: one pixel every 'per' clocks; per=0: random gaps.
  // rst_line / chg_line < 0 disable the mid-frame reset / window change.
  task automatic active(input int per, input int rst_line, input int chg_line,
                        input int ca, input int cb, input int cc, input int cd);
    int gaps;
    g_w = IMG_W;
    g_h = IMG_H;
    de_seen = 0;
    for (int y = 0; y < IMG_H; y++) begin
      if (y == rst_line) repeat (2) step(1, 0, 1, 0, -1, -1);
      if (y == chg_line) set_win(ca, cb, cc, cd);
      repeat (HB) step(0, 0, 1, 0, -1, -1);
      for (int x = 0; x < IMG_W; x++) begin
        step(0, 0, 0, 1, x, y);
        gaps = (per > 0) ? per - 1 : int'($urandom_range(0, 3));
        repeat (gaps) step(0, 0, 0, 0, -1, -1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; vs = 1'b1; hs = 1'b1; de = 1'b0; di = '0;
    set_win(0, IMG_W, 0, IMG_H);
    wxs = 0; wxsz = 0; wys = 0; wysz = 0;
    g_w = IMG_W; g_h = IMG_H; de_seen = 0; v_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_do_o", do_o, 0);
    check("rst_de_o", de_o, 0);
    check("rst_hs_o", hs_o, 1);
    check("rst_vs_o", vs_o, 1);
    check("rst_pix_count_o", pix_count_o, 0);
`ifdef VID_CROP_STAT_EN
    check("rst_frame_w_o", frame_w_o, 0);
    check("rst_frame_h_o", frame_h_o, 0);
`endif
    repeat (2) step(1, 1, 1, 0, -1, -1);

    // Full window, dense: pass-through
    set_win(0, IMG_W, 0, IMG_H);
    vblank();
    active(1, -1, -1, 0, 0, 0, 0);
    vblank();
    check("t1_de_total", de_seen, IMG_W * IMG_H);
    check("t1_pix_count", v_pc, IMG_W);
`ifdef VID_CROP_STAT_EN
    check("t6_frame_w", frame_w_o, IMG_W);
    check("t6_frame_h", frame_h_o, IMG_H);
`endif

    // Inner window, DE every 4th clock: 15 lines x 20 px
    set_win(10, 20, 5, 15);
    active(4, -1, -1, 0, 0, 0, 0);
    vblank();
    check("t2_de_total", de_seen, 20 * 15);
    check("t2_pix_count", v_pc, 0);

    // Window overhanging the image: 10 px x 5 lines
    set_win(30, 20, 25, 10);
    active(1, -1, -1, 0, 0, 0, 0);
    vblank();
    check("t3_de_total", de_seen, 10 * 5);
    check("t3_pix_count", v_pc, 10);

    // Empty windows
    set_win(0, 0, 0, IMG_H);
    active(1, -1, -1, 0, 0, 0, 0);
    vblank();
    check("t4a_de_total", de_seen, 0);
    set_win(70, 10, 0, IMG_H);
    active(0, -1, -1, 0, 0, 0, 0);
    vblank();
    check("t4b_de_total", de_seen, 0);
    set_win(16'hFFF0, 16'h0020, 16'hFFF8, 16'h0010);
    active(1, -1, -1, 0, 0, 0, 0);
    vblank();
    check("t4c_de_total", de_seen, 0);

    // Reset mid-frame, then window change mid-frame (applied next frame)
    set_win(0, IMG_W, 0, IMG_H);
    active(1, 15, -1, 0, 0, 0, 0);
    vblank();
    check("t5_rst_frame_de", de_seen, 15 * IMG_W);
    set_win(5, 10, 3, 4);
    active(1, -1, 10, 0, IMG_W, 0, IMG_H);
    vblank();
    check("t5_frame1_de", de_seen, 10 * 4);
    active(1, -1, -1, 0, 0, 0, 0);
    vblank();
    check("t5_frame2_de", de_seen, IMG_W * IMG_H);

    // Random windows and random pixel density
    for (int f = 0; f < 6; f++) begin
      set_win(int'($urandom_range(0, 50)), int'($urandom_range(0, 50)),
              int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
      active(0, -1, -1, 0, 0, 0, 0);
      vblank();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
